// File: rtl/phot_window_counter_if.sv
// Result stream between the window counter and its consumer: head count,
// saturation flag, valid/ready handshake.
interface phot_window_counter_if #(
    parameter int CNT_W = 16
);
    logic [CNT_W-1:0] count_out;
    logic             count_sat;
    logic             count_valid;
    logic             count_ready;

    modport master (
        output count_out,
        output count_sat,
        output count_valid,
        input  count_ready
    );

    modport slave (
        input  count_out,
        input  count_sat,
        input  count_valid,
        output count_ready
    );
endinterface

// File: rtl/phot_window_counter.sv
// Counts pulse rising edges inside programmable windows, single-shot or
// back-to-back, and queues one saturating count per window in a FWFT FIFO.
module phot_window_counter #(
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pulse_in,
    input  logic [31:0]           window_len,
    input  logic                  continuous,
    input  logic                  start,
    input  logic                  stop,
    phot_window_counter_if.master res,
    output logic                  busy,
    output logic                  lost
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_COUNT = 1'b1} state_t;

    state_t             state_r, state_n;
    logic               pulse_d_r;
    logic [31:0]        len_r, len_n;
    logic               cont_r, cont_n;
    logic               stop_seen_r, stop_seen_n;
    logic [31:0]        win_cnt_r, win_cnt_n;
    logic [CNT_W-1:0]   ev_cnt_r, ev_cnt_n;
    logic               sat_r, sat_n;
    logic               lost_r, lost_n;

    logic [CNT_W-1:0]   mem_cnt_r [FIFO_DEPTH];
    logic               mem_sat_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]     fill_r;

    logic               edge_s;
    logic [CNT_W-1:0]   ev_plus_s;
    logic               sat_plus_s;
    logic               win_end_s;
    logic               full_s;
    logic               pop_s;
    logic               push_s;
    logic               drop_s;
    logic               valid_s;

    // Edge detect, saturating event increment and FIFO handshake decode.
    always_comb begin
        edge_s = pulse_in & ~pulse_d_r;
        if (edge_s && !(&ev_cnt_r)) begin
            ev_plus_s = ev_cnt_r + CNT_W'(1);
        end else begin
            ev_plus_s = ev_cnt_r;
        end
        sat_plus_s = sat_r | (&ev_plus_s);
        win_end_s  = (state_r == ST_COUNT) && (win_cnt_r == (len_r - 32'd1));
        valid_s    = (fill_r != '0);
        full_s     = (fill_r == FULL_LVL);
        pop_s      = valid_s & res.count_ready;
        // A pop on a full FIFO frees the slot the concurrent push lands in.
        push_s     = win_end_s & (~full_s | pop_s);
        drop_s     = win_end_s & full_s & ~pop_s;
    end

    // Next-state and window datapath decisions.
    always_comb begin
        state_n     = state_r;
        len_n       = len_r;
        cont_n      = cont_r;
        stop_seen_n = stop_seen_r;
        win_cnt_n   = win_cnt_r;
        ev_cnt_n    = ev_cnt_r;
        sat_n       = sat_r;
        lost_n      = lost_r | drop_s;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_n     = ST_COUNT;
                    len_n       = (window_len == 32'd0) ? 32'd1 : window_len;
                    cont_n      = continuous;
                    stop_seen_n = 1'b0;
                    win_cnt_n   = 32'd0;
                    ev_cnt_n    = '0;
                    sat_n       = 1'b0;
                    lost_n      = 1'b0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (win_end_s) begin
                    // Edges in the closing cycle belong to the closing window.
                    win_cnt_n   = 32'd0;
                    ev_cnt_n    = '0;
                    sat_n       = 1'b0;
                    stop_seen_n = 1'b0;
                    if (cont_r && !(stop_seen_r || stop)) begin
                        state_n = ST_COUNT;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    win_cnt_n   = win_cnt_r + 32'd1;
                    ev_cnt_n    = ev_plus_s;
                    sat_n       = sat_plus_s;
                    stop_seen_n = stop_seen_r | stop;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Control and window state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            pulse_d_r   <= 1'b0;
            len_r       <= 32'd1;
            cont_r      <= 1'b0;
            stop_seen_r <= 1'b0;
            win_cnt_r   <= 32'd0;
            ev_cnt_r    <= '0;
            sat_r       <= 1'b0;
            lost_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            pulse_d_r   <= pulse_in;
            len_r       <= len_n;
            cont_r      <= cont_n;
            stop_seen_r <= stop_seen_n;
            win_cnt_r   <= win_cnt_n;
            ev_cnt_r    <= ev_cnt_n;
            sat_r       <= sat_n;
            lost_r      <= lost_n;
        end
    end

    // Result FIFO storage, pointers and fill level.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            fill_r   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_cnt_r[i] <= '0;
                mem_sat_r[i] <= 1'b0;
            end
        end else begin
            if (push_s) begin
                mem_cnt_r[wr_ptr_r] <= ev_plus_s;
                mem_sat_r[wr_ptr_r] <= sat_plus_s;
                wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fill_r <= fill_r + (PTR_W+1)'(1);
                2'b01:   fill_r <= fill_r - (PTR_W+1)'(1);
                default: fill_r <= fill_r;
            endcase
        end
    end

    assign res.count_valid = valid_s;
    assign res.count_out   = valid_s ? mem_cnt_r[rd_ptr_r] : '0;
    assign res.count_sat   = valid_s ? mem_sat_r[rd_ptr_r] : 1'b0;
    assign busy            = (state_r == ST_COUNT);
    assign lost            = lost_r;
endmodule

// File: tb/tb_phot_window_counter.sv
// Directed bench for phot_window_counter: a 16-bit and a 4-bit counter share
// the same stimulus and are checked against hand-computed results.
module tb_phot_window_counter;
    logic        clk = 1'b0;
    logic        rst;
    logic        pulse_in;
    logic [31:0] window_len;
    logic        continuous;
    logic        start;
    logic        stop;
    logic        ready;
    logic        busy_a, busy_b, lost_a, lost_b;
    int          total = 0;
    int          bad   = 0;
    logic [63:0] pat;

    phot_window_counter_if #(.CNT_W(16)) if_a ();
    phot_window_counter_if #(.CNT_W(4))  if_b ();

    assign if_a.count_ready = ready;
    assign if_b.count_ready = ready;

    phot_window_counter #(.CNT_W(16), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .window_len(window_len),
        .continuous(continuous), .start(start), .stop(stop),
        .res(if_a.master), .busy(busy_a), .lost(lost_a)
    );

    phot_window_counter #(.CNT_W(4), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .window_len(window_len),
        .continuous(continuous), .start(start), .stop(stop),
        .res(if_b.master), .busy(busy_b), .lost(lost_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string tag, input logic v, input logic [31:0] o);
        chk({tag, "_valid_a"}, 32'(if_a.count_valid), 32'(v));
        chk({tag, "_out_a"},   32'(if_a.count_out), o);
        chk({tag, "_valid_b"}, 32'(if_b.count_valid), 32'(v));
        chk({tag, "_out_b"},   32'(if_b.count_out), o);
    endtask

    task automatic stat(input string tag, input logic b, input logic l);
        chk({tag, "_busy_a"}, 32'(busy_a), 32'(b));
        chk({tag, "_busy_b"}, 32'(busy_b), 32'(b));
        chk({tag, "_lost_a"}, 32'(lost_a), 32'(l));
        chk({tag, "_lost_b"}, 32'(lost_b), 32'(l));
    endtask

    task automatic do_start(input logic [31:0] len, input logic cont);
        window_len = len;
        continuous = cont;
        pulse_in   = 1'b0;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic pop();
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pulse_in = 1'b0; window_len = 32'd0; continuous = 1'b0;
        start = 1'b0; stop = 1'b0; ready = 1'b0;
        tick(); tick();
        head("rst", 1'b0, 32'd0);
        stat("rst", 1'b0, 1'b0);
        chk("rst_sat_a", 32'(if_a.count_sat), 32'd0);
        rst = 1'b0;
        tick();

        // Single window of 10 with edges at cycles 2, 5, 8.
        do_start(32'd10, 1'b0);
        stat("t1_start", 1'b1, 1'b0);
        pat = 64'h124;
        for (int i = 1; i <= 10; i++) begin
            pulse_in = pat[i];
            tick();
            if (i == 9) head("t1_c9", 1'b0, 32'd0);
        end
        pulse_in = 1'b0;
        head("t1_end", 1'b1, 32'd3);
        chk("t1_sat_a", 32'(if_a.count_sat), 32'd0);
        stat("t1_end", 1'b0, 1'b0);
        tick();
        head("t1_hold", 1'b1, 32'd3);
        pop();
        head("t1_pop", 1'b0, 32'd0);

        // Continuous windows of 5, pulse every other clock, stop in window 4.
        ready = 1'b1;
        do_start(32'd5, 1'b1);
        for (int i = 1; i <= 22; i++) begin
            pulse_in = i[0];
            stop     = (i == 17);
            tick();
            if (i == 5)  head("t2_w1", 1'b1, 32'd3);
            if (i == 6)  head("t2_w1pop", 1'b0, 32'd0);
            if (i == 10) head("t2_w2", 1'b1, 32'd2);
            if (i == 15) head("t2_w3", 1'b1, 32'd3);
            if (i == 19) stat("t2_w4mid", 1'b1, 1'b0);
            if (i == 20) begin
                head("t2_w4", 1'b1, 32'd2);
                stat("t2_w4", 1'b0, 1'b0);
            end
            if (i == 22) begin
                head("t2_idle", 1'b0, 32'd0);
                stat("t2_idle", 1'b0, 1'b0);
            end
        end
        pulse_in = 1'b0; stop = 1'b0; ready = 1'b0;

        // Boundary edges: last cycle of window 1, first cycle of window 3.
        do_start(32'd4, 1'b1);
        pat = 64'h12B4;
        for (int i = 1; i <= 12; i++) begin
            pulse_in = pat[i];
            stop     = (i == 10);
            tick();
        end
        pulse_in = 1'b0; stop = 1'b0;
        stat("t3_end", 1'b0, 1'b0);
        head("t3_r1", 1'b1, 32'd2);
        pop();
        head("t3_r2", 1'b1, 32'd1);
        pop();
        head("t3_r3", 1'b1, 32'd2);
        pop();
        head("t3_empty", 1'b0, 32'd0);

        // Zero length acts as a one-clock window.
        do_start(32'd0, 1'b0);
        pulse_in = 1'b1;
        tick();
        pulse_in = 1'b0;
        head("t3_len0", 1'b1, 32'd1);
        stat("t3_len0", 1'b0, 1'b0);
        pop();

        // 20 edges in one window: 16-bit counter exact, 4-bit counter saturates.
        do_start(32'd40, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            pulse_in = i[0];
            tick();
        end
        pulse_in = 1'b0;
        chk("t4_out_a", 32'(if_a.count_out), 32'd20);
        chk("t4_sat_a", 32'(if_a.count_sat), 32'd0);
        chk("t4_out_b", 32'(if_b.count_out), 32'd15);
        chk("t4_sat_b", 32'(if_b.count_sat), 32'd1);
        pop();

        // Full FIFO: pop+push at window 5 keeps it, window 6 is dropped.
        do_start(32'd3, 1'b1);
        pat = 64'h2AA90;
        for (int i = 1; i <= 18; i++) begin
            pulse_in = pat[i];
            ready    = (i == 15);
            stop     = (i == 17);
            tick();
            if (i == 3)  head("t5_w1", 1'b1, 32'd0);
            if (i == 12) stat("t5_full", 1'b1, 1'b0);
            if (i == 15) begin
                head("t5_pp", 1'b1, 32'd1);
                stat("t5_pp", 1'b1, 1'b0);
            end
            if (i == 18) stat("t5_drop", 1'b0, 1'b1);
        end
        pulse_in = 1'b0; ready = 1'b0; stop = 1'b0;
        head("t5_q0", 1'b1, 32'd1);
        pop();
        head("t5_q1", 1'b1, 32'd2);
        pop();
        head("t5_q2", 1'b1, 32'd1);
        pop();
        head("t5_q3", 1'b1, 32'd2);
        pop();
        head("t5_empty", 1'b0, 32'd0);
        do_start(32'd1, 1'b0);
        stat("t5_restart", 1'b1, 1'b0);
        tick();
        pop();

        // Reset mid-window with two results queued, then a fresh run.
        do_start(32'd3, 1'b1);
        pat = 64'h52;
        for (int i = 1; i <= 8; i++) begin
            pulse_in = pat[i];
            tick();
        end
        head("t6_pre", 1'b1, 32'd1);
        pulse_in = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        head("t6_rst", 1'b0, 32'd0);
        stat("t6_rst", 1'b0, 1'b0);
        do_start(32'd4, 1'b0);
        pat = 64'hA;
        for (int i = 1; i <= 4; i++) begin
            pulse_in = pat[i];
            tick();
        end
        pulse_in = 1'b0;
        head("t6_fresh", 1'b1, 32'd2);
        stat("t6_fresh", 1'b0, 1'b0);
        pop();
        head("t6_empty", 1'b0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
